// File: rtl/game_ctrl.sv
// game_ctrl: match sequencer for the Pong datapath.
// It holds the ball at centre during serve and after a point, then releases it
// for play. It turns the ball block's score flags into per-player point
// counters and declares a winner at WIN_SCORE.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   x, y        VGA pixel column/row; (x==0, y==481) is the once-per-frame tick
//   start       single-cycle start pulse
//   score1/2    point flags from the ball block (edge-detected here)
//   ball_hold   1 = ball forced to centre with zero motion
//   serve_dir   0 = serve toward pad1 side, 1 = toward pad2 side
//   score_p1/2  player points
//   state       current state encoding (debug/display)
//   game_over   match finished
//   winner      00 none, 01 player 1, 10 player 2
//
// Optional build macro GAME_PAUSE_EN adds input pause, output ball_freeze and
// state PAUSED(5), which toggles with PLAY.
module game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       start,
  input  logic       score1,
  input  logic       score2,
`ifdef GAME_PAUSE_EN
  input  logic       pause,
  output logic       ball_freeze,
`endif
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] state,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
`ifdef GAME_PAUSE_EN
    , PAUSED = 3'd5
`endif
  } state_t;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  state_t     cur, nxt;
  logic [7:0] cnt, cnt_n;
  logic [3:0] p1_n, p2_n;
  logic [1:0] win_n;
  logic       dir_n, hold_n, over_n;
  // Two-stage sampling: the first stage registers the flag, the second keeps
  // the previous sample, so a point acts one cycle after the flag is seen.
  logic       s1_q, s1_qq, s2_q, s2_qq;
  logic       tick, edge1, edge2;
`ifdef GAME_PAUSE_EN
  logic       freeze_n;
`endif

  assign tick  = (y == 10'd481) && (x == 10'd0);
  assign edge1 = s1_q & ~s1_qq;
  assign edge2 = s2_q & ~s2_qq;
  assign state = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= IDLE;
      cnt       <= '0;
      score_p1  <= '0;
      score_p2  <= '0;
      winner    <= '0;
      serve_dir <= 1'b0;
      ball_hold <= 1'b1;
      game_over <= 1'b0;
      s1_q      <= 1'b0;
      s1_qq     <= 1'b0;
      s2_q      <= 1'b0;
      s2_qq     <= 1'b0;
`ifdef GAME_PAUSE_EN
      ball_freeze <= 1'b0;
`endif
    end else begin
      cur       <= nxt;
      cnt       <= cnt_n;
      score_p1  <= p1_n;
      score_p2  <= p2_n;
      winner    <= win_n;
      serve_dir <= dir_n;
      ball_hold <= hold_n;
      game_over <= over_n;
      s1_q      <= score1;
      s1_qq     <= s1_q;
      s2_q      <= score2;
      s2_qq     <= s2_q;
`ifdef GAME_PAUSE_EN
      ball_freeze <= freeze_n;
`endif
    end
  end

  always_comb begin
    nxt   = cur;
    cnt_n = cnt;
    p1_n  = score_p1;
    p2_n  = score_p2;
    win_n = winner;
    dir_n = serve_dir;
    case (cur)
      IDLE: begin
        if (start) begin
          p1_n  = '0;
          p2_n  = '0;
          win_n = '0;
          cnt_n = '0;
          nxt   = SERVE;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt == SERVE_LAST) begin
            cnt_n = '0;
            nxt   = PLAY;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        // Player 1 has priority; a simultaneous player 2 edge is dropped.
        if (edge1) begin
          p1_n = score_p1 + 4'd1;
          if (p1_n == WIN) begin
            nxt   = OVER;
            win_n = 2'b01;
          end else begin
            nxt   = POINT;
            dir_n = 1'b1;
          end
        end else if (edge2) begin
          p2_n = score_p2 + 4'd1;
          if (p2_n == WIN) begin
            nxt   = OVER;
            win_n = 2'b10;
          end else begin
            nxt   = POINT;
            dir_n = 1'b0;
          end
        end
`ifdef GAME_PAUSE_EN
        else if (pause) begin
          nxt = PAUSED;
        end
`endif
      end
      POINT: begin
        if (tick) begin
          if (cnt == POINT_LAST) begin
            cnt_n = '0;
            nxt   = SERVE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      OVER: begin
        if (start) begin
          p1_n  = '0;
          p2_n  = '0;
          win_n = '0;
          dir_n = 1'b0;
          cnt_n = '0;
          nxt   = SERVE;
        end
      end
`ifdef GAME_PAUSE_EN
      PAUSED: begin
        if (pause) nxt = PLAY;
      end
`endif
      default: nxt = IDLE;
    endcase

    // Moore outputs are registered from the next state so they line up with it.
`ifdef GAME_PAUSE_EN
    hold_n   = !((nxt == PLAY) || (nxt == PAUSED));
    freeze_n = (nxt == PAUSED);
`else
    hold_n   = (nxt != PLAY);
`endif
    over_n   = (nxt == OVER);
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Match sequencer for the Pong datapath. It holds the ball at centre during serve and after a point, releases it for play, and converts the ball block's score1/score2 flags into per-player point counters. It declares a winner at WIN_SCORE. It sits between the VGA controller (x, y), the ball block (score flags in, hold control out) and the score display.

Parameters:
WIN_SCORE, 7, points needed to win; legal 1..15
SERVE_FRAMES, 120, refresh ticks the ball is held at centre before release; legal 1..255
POINT_FRAMES, 60, refresh ticks of pause after a point before the next serve; legal 1..255

Ports:
clk  in  1  system clock, 100MHz
reset  in  1  asynchronous, active-low reset
x  in  10  VGA pixel column
y  in  10  VGA pixel row
start  in  1  single-cycle start pulse, debounced upstream
score1  in  1  point flag for player 1 from the ball block
score2  in  1  point flag for player 2 from the ball block
ball_hold  out  1  1 = ball block forces the ball to centre and zero motion
serve_dir  out  1  0 = serve toward pad1 side, 1 = toward pad2 side
score_p1  out  4  player 1 points
score_p2  out  4  player 2 points
state  out  3  current state encoding, for debug and display
game_over  out  1  match finished
winner  out  2  00 none, 01 player 1, 10 player 2

Behaviour:
- Clock and reset: already decided — one clock (clk); reset is asynchronous and active-low.
- Refresh tick: tick = (y == 481 && x == 0), evaluated combinationally. All frame counting advances only on tick cycles.
- Reset values: state=IDLE(0), ball_hold=1, serve_dir=0, score_p1=0, score_p2=0, game_over=0, winner=00, frame counter=0, score edge registers=0.
- Reset may assert at any time, including mid-serve or mid-point. All registers return to the reset values immediately. No partial score survives.
- Score flags: score1 and score2 are edge-detected using registered previous values. A point is a rising edge (current=1, previous=0). A flag held high scores once only.
- Score edges are honoured only in PLAY. Edges in any other state are discarded, but the previous-value registers still track the inputs.
- States (Moore outputs, registered):
  - IDLE(0): ball_hold=1. On start: clear scores, winner=00, counter=0, go to SERVE.
  - SERVE(1): ball_hold=1. On each tick, counter+1. On the tick where counter==SERVE_FRAMES-1: counter=0, go to PLAY.
  - PLAY(2): ball_hold=0. On a player 1 edge: score_p1+1. On a player 2 edge: score_p2+1.
    - If the new score==WIN_SCORE, go to OVER and set winner.
    - Otherwise go to POINT and set serve_dir toward the side that conceded: after a player 1 point serve_dir=1; after a player 2 point serve_dir=0.
  - POINT(3): ball_hold=1. Counts ticks like SERVE using POINT_FRAMES, then goes to SERVE with counter=0.
  - OVER(4): ball_hold=1, game_over=1, winner held. On start: clear scores, winner=00, game_over=0, serve_dir=0, go to SERVE.
- Simultaneous edges: if both edges arrive in the same cycle in PLAY, player 1 has priority and the player 2 edge is dropped.
- Latency:
  - A score flag first sampled high in cycle N produces the incremented score and the new state on the edge ending cycle N+1 (one-cycle edge-detect latency).
  - A start pulse in cycle N changes state on the edge ending cycle N.
- Start in SERVE, PLAY or POINT is ignored.
- Scores never exceed WIN_SCORE, so no wrap-around of the 4-bit counters.
- A frame counter of 8 bits is sufficient. The compare is equality, so a tick is never skipped.

Optional Feature:
GAME_PAUSE_EN:
- Defined:
  - Adds input port pause (single-cycle pulse, debounced upstream) and state PAUSED(5).
  - A pause in PLAY goes to PAUSED. In PAUSED, ball_hold=0 and a further output ball_freeze=1, which tells the ball block to stop position updates without recentring.
  - A pause in PAUSED returns to PLAY. Score edges are discarded while PAUSED. pause in other states is ignored.
  - ball_freeze resets to 0.
- Undefined: no pause port, no ball_freeze port, no PAUSED state; the encoding 5 never appears.

Test Plan:
1. Reset low mid-SERVE with counter=40 -> all outputs at reset values immediately; state=0, ball_hold=1.
2. SERVE_FRAMES=3: start pulse, then 3 ticks -> state=1 for 3 ticks, state=2 and ball_hold=0 on the 3rd tick edge; exactly 3 ticks, no more.
3. In PLAY, raise score2 and hold it high for 5 frames -> score_p2=1 (not 5), state=3, serve_dir=0; after POINT_FRAMES ticks state=1.
4. In PLAY, assert score1 and score2 in the same cycle -> score_p1+1, score_p2 unchanged, serve_dir=1.
5. WIN_SCORE=2: give player 1 two points -> score_p1=2, state=4, game_over=1, winner=01; then start -> scores 0, game_over=0, state=1.
6. With GAME_PAUSE_EN defined: pause in PLAY -> state=5, ball_freeze=1; assert score1 while paused -> score unchanged; pause again -> state=2, ball_freeze=0.
